// File: rtl/lcd_text_writer.sv
// lcd_text_writer: turns a stream of host character bytes into HD44780-style
// instruction/data words for a downstream LCD driver, tracking the cursor.
//
// Handshakes (both sides): a word moves when valid and ready are high in the
// same cycle; once valid is raised, valid and its payload stay unchanged
// until that transfer happens (only reset may withdraw it).
//
// Optional feature: define LCD_TEXT_AUTOWRAP_EN to make a printable byte at
// the end of a line move to the start of the other line before printing.
// Without it such a byte is silently dropped.
module lcd_text_writer #(
    parameter int COLS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    input  logic       cmd_ready,
    output logic       cursor_line,
    output logic [5:0] cursor_col,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_CHAR  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [5:0] COLS_W = 6'(COLS);

    state_t     state, state_next;
    logic       armed;          // low for the first cycle after reset release
    logic [7:0] pend_char, pend_char_next;
    logic       pend_wrap, pend_wrap_next;  // S_ADDR is followed by S_CHAR
    logic       valid_next, rs_next;
    logic [7:0] data_next;
    logic       line_next;
    logic [5:0] col_next;

    logic accept, transfer, printable;

    assign in_ready  = reset && armed && init_done && (state == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign transfer  = cmd_valid && cmd_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign dbg_state = state;

    // State and all command/cursor outputs are registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            armed       <= 1'b0;
            pend_char   <= 8'h00;
            pend_wrap   <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_rs      <= 1'b0;
            cmd_data    <= 8'h00;
            cursor_line <= 1'b0;
            cursor_col  <= 6'd0;
        end else begin
            state       <= state_next;
            armed       <= 1'b1;
            pend_char   <= pend_char_next;
            pend_wrap   <= pend_wrap_next;
            cmd_valid   <= valid_next;
            cmd_rs      <= rs_next;
            cmd_data    <= data_next;
            cursor_line <= line_next;
            cursor_col  <= col_next;
        end
    end

    // Next-state, next command word and cursor bookkeeping
    always_comb begin
        state_next     = state;
        pend_char_next = pend_char;
        pend_wrap_next = pend_wrap;
        valid_next     = cmd_valid;
        rs_next        = cmd_rs;
        data_next      = cmd_data;
        line_next      = cursor_line;
        col_next       = cursor_col;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        if (cursor_col < COLS_W) begin
                            state_next = S_CHAR;
                            valid_next = 1'b1;
                            rs_next    = 1'b1;
                            data_next  = in_data;
                        end else begin
`ifdef LCD_TEXT_AUTOWRAP_EN
                            state_next     = S_ADDR;
                            valid_next     = 1'b1;
                            rs_next        = 1'b0;
                            data_next      = cursor_line ? 8'h80 : 8'hC0;
                            pend_char_next = in_data;
                            pend_wrap_next = 1'b1;
`endif
                        end
                    end else if (in_data == 8'h0A) begin
                        state_next     = S_ADDR;
                        valid_next     = 1'b1;
                        rs_next        = 1'b0;
                        data_next      = cursor_line ? 8'h80 : 8'hC0;
                        pend_wrap_next = 1'b0;
                    end else if (in_data == 8'h0C) begin
                        state_next = S_CLEAR;
                        valid_next = 1'b1;
                        rs_next    = 1'b0;
                        data_next  = 8'h01;
                    end
                    // every other code is swallowed without a command
                end
            end
            S_ADDR: begin
                if (transfer) begin
                    line_next = ~cursor_line;
                    col_next  = 6'd0;
                    if (pend_wrap) begin
                        state_next     = S_CHAR;
                        rs_next        = 1'b1;
                        data_next      = pend_char;
                        pend_wrap_next = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        valid_next = 1'b0;
                    end
                end
            end
            S_CHAR: begin
                if (transfer) begin
                    state_next = S_IDLE;
                    valid_next = 1'b0;
                    col_next   = cursor_col + 6'd1;
                end
            end
            S_CLEAR: begin
                if (transfer) begin
                    state_next = S_IDLE;
                    valid_next = 1'b0;
                    line_next  = 1'b0;
                    col_next   = 6'd0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
